// File: rtl/pwm_status_tx.sv
// Snapshots live per-channel PWM settings and streams them back to the host
// as 5-word status frames (one per channel) on the UDP transmit AXI-Stream.
module pwm_status_tx #(
  parameter int unsigned PWM_NUM          = 5,
  parameter logic [7:0]  ID_PWM_STATUS    = 8'd1,
  parameter int unsigned CLK_FREQ         = 100000000,
  parameter int unsigned REPORT_PERIOD_US = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PWM_NUM*32-1:0]  pwm_frequency,
  input  logic [PWM_NUM*7-1:0]   pwm_duty,
  input  logic [PWM_NUM-1:0]     pwm_en,
  input  logic                   report_req,
  output logic [31:0]            tx_axis_udp_tdata,
  output logic                   tx_axis_udp_tvalid,
  input  logic                   tx_axis_udp_tready,
  output logic                   tx_axis_udp_tlast,
  output logic [7:0]             tx_axis_udp_tuser,
  output logic                   busy
);

  localparam int unsigned CYC_PER_US = CLK_FREQ / 32'd1000000;
  localparam int unsigned TC = (REPORT_PERIOD_US == 0) ? 32'd0
                             : CYC_PER_US * REPORT_PERIOD_US - 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_NEXT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  ch_q, ch_d;
  logic [2:0]  w_q, w_d;
  logic [31:0] freq_q, freq_d;
  logic [6:0]  duty_q, duty_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        retrig_q, retrig_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  tuser_q, tuser_d;
  logic        busy_q, busy_d;

  logic        tick, trig;
  logic [31:0] ld_freq;
  logic [6:0]  ld_duty;
  logic        ld_en;
  logic [2:0]  w_nx;

  function automatic logic [31:0] word_of(input logic [2:0] w, input logic [7:0] ch,
                                          input logic [31:0] f, input logic [6:0] d,
                                          input logic e);
    case (w)
      3'd0:    word_of = {24'b0, ch};
      3'd1:    word_of = f;
      3'd2:    word_of = {25'b0, d};
      3'd3:    word_of = 32'b0;
      default: word_of = {31'b0, e};
    endcase
  endfunction

  // Free-running report timer; never stalled by bursts or backpressure.
  always_comb begin
    tick  = (REPORT_PERIOD_US != 0) && (tmr_q == TC);
    tmr_d = (REPORT_PERIOD_US == 0 || tick) ? 32'd0 : tmr_q + 32'd1;
    trig  = tick | report_req;
  end

  always_comb begin
    ld_freq = '0;
    ld_duty = '0;
    ld_en   = 1'b0;
    for (int i = 0; i < PWM_NUM; i++) begin
      if (ch_q == 8'(i)) begin
        ld_freq = pwm_frequency[32*i +: 32];
        ld_duty = pwm_duty[7*i +: 7];
        ld_en   = pwm_en[i];
      end
    end
    if (ld_duty > 7'd100) ld_duty = 7'd100;
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    w_d      = w_q;
    freq_d   = freq_q;
    duty_d   = duty_q;
    en_d     = en_q;
    pend_d   = pend_q;
    retrig_d = retrig_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    busy_d   = busy_q;
    w_nx     = w_q + 3'd1;

    // Triggers arriving mid-burst collapse into a single pending burst.
    if (trig && state_q != S_IDLE && state_q != S_DONE) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        retrig_d = 1'b0;
        if (trig || retrig_q) begin
          state_d = S_LOAD;
          ch_d    = 8'd0;
        end
      end
      S_LOAD: begin
        freq_d   = ld_freq;
        duty_d   = ld_duty;
        en_d     = ld_en;
        w_d      = 3'd0;
        busy_d   = 1'b1;
        tvalid_d = 1'b1;
        tdata_d  = word_of(3'd0, ch_q, ld_freq, ld_duty, ld_en);
        tlast_d  = 1'b0;
        tuser_d  = ID_PWM_STATUS;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tvalid_q && tx_axis_udp_tready) begin
          if (w_q == 3'd4) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = '0;
            state_d  = S_NEXT;
          end else begin
            w_d     = w_nx;
            tdata_d = word_of(w_nx, ch_q, freq_q, duty_q, en_q);
            tlast_d = (w_nx == 3'd4);
          end
        end
      end
      S_NEXT: begin
        if (ch_q == 8'(PWM_NUM - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        busy_d   = 1'b0;
        retrig_d = pend_q | trig;
        pend_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      ch_q     <= '0;
      w_q      <= '0;
      freq_q   <= '0;
      duty_q   <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      retrig_q <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      ch_q     <= ch_d;
      w_q      <= w_d;
      freq_q   <= freq_d;
      duty_q   <= duty_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      retrig_q <= retrig_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_axis_udp_tdata  = tdata_q;
  assign tx_axis_udp_tvalid = tvalid_q;
  assign tx_axis_udp_tlast  = tlast_q;
  assign tx_axis_udp_tuser  = tuser_q;
  assign busy               = busy_q;

endmodule
